// File: rtl/da_slicer.sv
// -----------------------------------------------------------------------------
// da_slicer
//
// Bit-plane input stage for the distributed-arithmetic FIR core. Each accepted
// sample is shifted into a 64-tap delay line. The line is then presented to the
// DA core one bit-plane at a time, MSB (sign) plane first, as eight LUT address
// bytes. Each plane is handed over with a valid/ready handshake.
//
// Optional feature macro: DA_SLICER_FLUSH_EN adds a synchronous flush input.
//
// Ports
//   clk           sole clock, rising edge
//   resetn        asynchronous active-low reset
//   flush         (DA_SLICER_FLUSH_EN only) clears delay line and counter, forces idle
//   sample_in     two's-complement input sample, DW bits
//   sample_valid  sample_in is valid
//   sample_ready  block can accept a sample this cycle (idle)
//   A7..A0        LUT addresses for the current plane: An[k] = x[8n+k][b]
//   slice_valid   A7..A0 hold a valid plane
//   slice_ready   downstream consumes the plane this cycle
//   sign_slice    current plane is the sign plane (downstream subtracts)
//   frame_start   current plane is the first plane of the frame
//   frame_done    one-cycle pulse after the last plane is consumed
// -----------------------------------------------------------------------------
module da_slicer #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          resetn,
`ifdef DA_SLICER_FLUSH_EN
  input  logic          flush,
`endif
  input  logic [DW-1:0] sample_in,
  input  logic          sample_valid,
  output logic          sample_ready,
  output logic [7:0]    A7,
  output logic [7:0]    A6,
  output logic [7:0]    A5,
  output logic [7:0]    A4,
  output logic [7:0]    A3,
  output logic [7:0]    A2,
  output logic [7:0]    A1,
  output logic [7:0]    A0,
  output logic          slice_valid,
  input  logic          slice_ready,
  output logic          sign_slice,
  output logic          frame_start,
  output logic          frame_done
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

  state_t               state_q, state_nxt;
  logic signed [DW-1:0] x_q [64];
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        bit_sel;
  logic [63:0]          plane_q;
  logic [63:0]          plane_sel;
  logic                 accept_en, load_en, step_en, done_en;
  logic                 flush_w;

`ifdef DA_SLICER_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // cnt_q holds the index of the plane currently on the outputs; the next
  // plane to register is the sign plane on load, otherwise one below.
  assign bit_sel = (state_q == LOAD) ? CW'(DW - 1) : (cnt_q - CW'(1));

  always_comb begin
    plane_sel = '0;
    for (int i = 0; i < 64; i++) begin
      plane_sel[i] = x_q[i][bit_sel];
    end
  end

  assign A0 = plane_q[7:0];
  assign A1 = plane_q[15:8];
  assign A2 = plane_q[23:16];
  assign A3 = plane_q[31:24];
  assign A4 = plane_q[39:32];
  assign A5 = plane_q[47:40];
  assign A6 = plane_q[55:48];
  assign A7 = plane_q[63:56];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    accept_en = 1'b0;
    load_en   = 1'b0;
    step_en   = 1'b0;
    done_en   = 1'b0;
    if (flush_w) begin
      state_nxt = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (sample_valid) begin
            accept_en = 1'b1;
            state_nxt = LOAD;
          end
        end
        LOAD: begin
          load_en   = 1'b1;
          state_nxt = EMIT;
        end
        EMIT: begin
          if (slice_valid && slice_ready) begin
            if (cnt_q != '0) begin
              step_en = 1'b1;
            end else begin
              done_en   = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage boundary: delay line and plane register feed the DA core directly.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 64; i++) x_q[i] <= '0;
      cnt_q        <= CW'(DW - 1);
      plane_q      <= '0;
      slice_valid  <= 1'b0;
      sign_slice   <= 1'b0;
      frame_start  <= 1'b0;
      frame_done   <= 1'b0;
      sample_ready <= 1'b1;
    end else begin
      frame_done   <= done_en;
      sample_ready <= (state_nxt == IDLE);
      if (flush_w) begin
        for (int i = 0; i < 64; i++) x_q[i] <= '0;
        cnt_q       <= '0;
        plane_q     <= '0;
        slice_valid <= 1'b0;
        sign_slice  <= 1'b0;
        frame_start <= 1'b0;
      end else begin
        if (accept_en) begin
          for (int i = 63; i > 0; i--) x_q[i] <= x_q[i-1];
          x_q[0] <= sample_in;
        end
        if (load_en) begin
          plane_q     <= plane_sel;
          cnt_q       <= CW'(DW - 1);
          slice_valid <= 1'b1;
          sign_slice  <= 1'b1;
          frame_start <= 1'b1;
        end
        if (step_en) begin
          plane_q     <= plane_sel;
          cnt_q       <= cnt_q - CW'(1);
          sign_slice  <= 1'b0;
          frame_start <= 1'b0;
        end
        if (done_en) begin
          slice_valid <= 1'b0;
          sign_slice  <= 1'b0;
          frame_start <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_da_slicer.sv
// -----------------------------------------------------------------------------
// tb_da_slicer
//
// Scoreboard bench for da_slicer (DW = 16). The driver pushes the expected
// sequence of bit-planes for every accepted sample; a monitor pops and compares
// whenever a plane is consumed, and also watches frame_done and handshake hold.
// -----------------------------------------------------------------------------
module tb_da_slicer;

  localparam int DW = 16;

  typedef struct {
    logic [63:0] plane;
    int          b;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] sample_in;
  logic          sample_valid;
  logic          sample_ready;
  logic [7:0]    A7, A6, A5, A4, A3, A2, A1, A0;
  logic          slice_valid;
  logic          slice_ready;
  logic          sign_slice;
  logic          frame_start;
  logic          frame_done;
`ifdef DA_SLICER_FLUSH_EN
  logic          flush;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t          sb[$];
  logic [DW-1:0] mdl [64];
  logic          done_pending = 1'b0;
  logic          hold_prev    = 1'b0;
  logic [63:0]   prev_plane   = '0;
  logic          rand_ready   = 1'b0;
  int            stall_plane  = -1;
  int            stall_left   = 0;

  da_slicer #(.DW(DW)) dut (
    .clk          (clk),
    .resetn       (resetn),
`ifdef DA_SLICER_FLUSH_EN
    .flush        (flush),
`endif
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .A7           (A7),
    .A6           (A6),
    .A5           (A5),
    .A4           (A4),
    .A3           (A3),
    .A2           (A2),
    .A1           (A1),
    .A0           (A0),
    .slice_valid  (slice_valid),
    .slice_ready  (slice_ready),
    .sign_slice   (sign_slice),
    .frame_start  (frame_start),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: shift the tap line, then list every bit-plane MSB first.
  task automatic model_accept(input logic [DW-1:0] d);
    exp_t e;
    for (int i = 63; i > 0; i--) mdl[i] = mdl[i-1];
    mdl[0] = d;
    for (int b = DW - 1; b >= 0; b--) begin
      e.b = b;
      for (int t = 0; t < 64; t++) e.plane[t] = (mdl[t] >> b) & 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mdl[i] = '0;
    sb.delete();
  endtask

  task automatic send(input logic [DW-1:0] d, output int acc);
    int w;
    @(posedge clk);
    #1;
    sample_in    = d;
    sample_valid = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (sample_ready || w >= 500) break;
      w++;
    end
    if (!sample_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no sample_ready expected ready within 500 cycles");
      sample_valid = 1'b0;
      acc = -1;
      return;
    end
    model_accept(d);
    @(posedge clk);
    #1;
    acc          = cyc;
    sample_valid = 1'b0;
    sample_in    = '0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || slice_valid) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d planes left expected 0", sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // slice_ready driver: always-ready, random, or a directed 5-cycle stall.
  initial forever begin
    @(posedge clk);
    #1;
    if (stall_plane >= 0 && slice_valid && sb.size() > 0 && sb[0].b == stall_plane) begin
      stall_left  = 5;
      stall_plane = -1;
    end
    if (stall_left > 0) begin
      slice_ready = 1'b0;
      stall_left--;
    end else begin
      slice_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard.
  initial forever begin
    logic [63:0] act;
    exp_t        e;
    @(negedge clk);
    if (resetn !== 1'b1) begin
      hold_prev    = 1'b0;
      done_pending = 1'b0;
      continue;
    end
    act = {A7, A6, A5, A4, A3, A2, A1, A0};
    if (slice_valid) chk("ready_while_busy", 64'(sample_ready), 64'(0));
    if (frame_done || done_pending) chk("frame_done", 64'(frame_done), 64'(done_pending));
    done_pending = 1'b0;
    if (hold_prev) begin
      chk("hold_valid", 64'(slice_valid), 64'(1));
      chk("hold_addr", act, prev_plane);
    end
    hold_prev  = slice_valid && !slice_ready;
    prev_plane = act;
    if (slice_valid && slice_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_plane: got plane %0h expected none", act);
      end else begin
        e = sb.pop_front();
        chk($sformatf("plane_b%0d", e.b), act, e.plane);
        chk("sign_slice", 64'(sign_slice), 64'(e.b == DW - 1));
        chk("frame_start", 64'(frame_start), 64'(e.b == DW - 1));
        done_pending = (e.b == 0);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int k;
    resetn       = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    slice_ready  = 1'b1;
`ifdef DA_SLICER_FLUSH_EN
    flush        = 1'b0;
`endif
    for (int i = 0; i < 64; i++) mdl[i] = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_sample_ready", 64'(sample_ready), 64'(1));
    chk("rst_slice_valid", 64'(slice_valid), 64'(0));
    chk("rst_addr", {A7, A6, A5, A4, A3, A2, A1, A0}, 64'h0);
    chk("rst_frame_done", 64'(frame_done), 64'(0));
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(sample_ready), 64'(1));
    chk("post_rst_valid", 64'(slice_valid), 64'(0));

    // Impulse with slice_ready held high; frame_done latency DW+1
    send(16'h0001, acc);
    k = 0;
    forever begin
      @(negedge clk);
      if (frame_done || k >= 100) break;
      k++;
    end
    if (frame_done) begin
      chk("done_latency", 64'(cyc - acc), 64'(DW + 1));
      chk("ready_after_frame", 64'(sample_ready), 64'(1));
    end else begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no frame_done expected pulse %0d cycles after accept", DW + 1);
    end
    drain();

    // Sign plane: 63 zeros then 0x8000 leaves only x[0] = 0x8000
    for (int i = 0; i < 63; i++) send(16'h0000, acc);
    send(16'h8000, acc);
    drain();

    // Backpressure on plane 12
    stall_plane = 12;
    send(16'h5A5A, acc);
    drain();

    // Delay-line walk: one 1 then 63 zeros, then one more zero
    send(16'h0001, acc);
    for (int i = 0; i < 64; i++) send(16'h0000, acc);
    drain();

    // Randomized samples, random backpressure, held sample_valid while busy
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(16'($urandom), acc);
    end
    drain();
    rand_ready = 1'b0;

    // Reset mid-frame: outputs return to reset values, no frame_done
    send(16'h1234, acc);
    repeat (6) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst_valid", 64'(slice_valid), 64'(0));
    chk("midrst_ready", 64'(sample_ready), 64'(1));
    chk("midrst_addr", {A7, A6, A5, A4, A3, A2, A1, A0}, 64'h0);
    chk("midrst_sign", 64'(sign_slice), 64'(0));
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (25) @(negedge clk);
    chk("midrst_no_restart", 64'(slice_valid), 64'(0));
    send(16'h00A5, acc);
    drain();

`ifdef DA_SLICER_FLUSH_EN
    // Flush while plane 9 is pending (held by a stall)
    send(16'hFFFF, acc);
    stall_plane = 9;
    k = 0;
    forever begin
      @(posedge clk);
      #2;
      if ((stall_left > 0 && sb.size() > 0 && sb[0].b == 9) || k >= 200) break;
      k++;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    stall_left   = 0;
    hold_prev    = 1'b0;
    done_pending = 1'b0;
    model_clear();
    chk("flush_valid", 64'(slice_valid), 64'(0));
    chk("flush_done", 64'(frame_done), 64'(0));
    repeat (5) @(negedge clk);
    chk("flush_idle", 64'(sample_ready), 64'(1));
    send(16'h0003, acc);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
